// File: rtl/dm_access_if.sv
// Pipeline/memory-side bundle of the data-memory access unit. The master side is the
// environment (pipeline request plus memory response); the slave side is the unit.
interface dm_access_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_ctl;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output req_valid, req_we, req_ctl, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_ctl, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/dm_access_unit.sv
// Data-memory access unit: sized little-endian loads/stores, splitting accesses that
// straddle a bus word into two beats and merging/extending the load result.
module dm_access_unit #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  dm_access_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BEAT1 = 2'd1;
  localparam logic [1:0] BEAT2 = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state;
  logic              we_q;
  logic [2:0]        ctl_q;
  logic [OFF_W-1:0]  off_q;
  logic              split_q;
  logic [BYTES-1:0]  be_hi_q;
  logic [DATA_W-1:0] wdata_hi_q;
  logic [DATA_W-1:0] rdata_lo_q;

  logic [3:0]          sz;
  logic [OFF_W-1:0]    off;
  logic [2:0]          amask;
  logic                misalign;
  logic                split;
  logic                bad_ctl;
  logic                req_err;
  logic [2*BYTES-1:0]  ones;
  logic [2*BYTES-1:0]  be_wide;
  logic [2*DATA_W-1:0] wdata_wide;
  logic [ADDR_W-1:0]   addr_aligned;

  assign bus.req_ready = (state == IDLE);

  // Both beats' lane layout comes from one double-width shift: low half is beat 1, high half beat 2.
  always_comb begin
    sz           = 4'd1 << bus.req_ctl[2:1];
    off          = bus.req_addr[OFF_W-1:0];
    amask        = 3'(sz - 4'd1);
    misalign     = |(bus.req_addr[2:0] & amask);
    split        = (5'(off) + 5'(sz)) > 5'(BYTES);
    bad_ctl      = (bus.req_ctl == 3'd7) ||
                   ((DATA_W == 32) && (bus.req_ctl == 3'd5 || bus.req_ctl == 3'd6));
    req_err      = bad_ctl || (!ALLOW_MISALIGN && misalign);
    ones         = ((2*BYTES)'(1) << sz) - (2*BYTES)'(1);
    be_wide      = ones << off;
    wdata_wide   = {{DATA_W{1'b0}}, bus.req_wdata} << {off, 3'b000};
    addr_aligned = bus.req_addr & ~ADDR_W'(BYTES - 1);
  end

  function automatic logic [DATA_W-1:0] load_result(input logic [DATA_W-1:0] hi,
                                                    input logic [DATA_W-1:0] lo,
                                                    input logic [OFF_W-1:0]  o,
                                                    input logic [2:0]        c);
    logic [2*DATA_W-1:0] cat;
    logic [DATA_W-1:0]   raw;
    logic [DATA_W-1:0]   mask;
    logic                sgn;
    cat = {hi, lo} >> {o, 3'b000};
    raw = cat[DATA_W-1:0];
    case (c[2:1])
      2'd0:    begin mask = DATA_W'(8'hFF);         sgn = raw[7];        end
      2'd1:    begin mask = DATA_W'(16'hFFFF);      sgn = raw[15];       end
      2'd2:    begin mask = DATA_W'(32'hFFFF_FFFF); sgn = raw[31];       end
      default: begin mask = '1;                     sgn = raw[DATA_W-1]; end
    endcase
    if (c[0]) sgn = 1'b0;
    return (raw & mask) | (sgn ? ~mask : '0);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      we_q          <= 1'b0;
      ctl_q         <= '0;
      off_q         <= '0;
      split_q       <= 1'b0;
      be_hi_q       <= '0;
      wdata_hi_q    <= '0;
      rdata_lo_q    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          we_q       <= bus.req_we;
          ctl_q      <= bus.req_ctl;
          off_q      <= off;
          split_q    <= split;
          be_hi_q    <= be_wide[2*BYTES-1:BYTES];
          wdata_hi_q <= wdata_wide[2*DATA_W-1:DATA_W];
          if (req_err) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
          end else begin
            state         <= BEAT1;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.req_we;
            bus.mem_addr  <= addr_aligned;
            bus.mem_be    <= be_wide[BYTES-1:0];
            bus.mem_wdata <= wdata_wide[DATA_W-1:0];
          end
        end
        BEAT1: if (bus.mem_ack) begin
          if (split_q) begin
            // mem_req stays high so the second beat issues back-to-back
            state         <= BEAT2;
            rdata_lo_q    <= bus.mem_rdata;
            bus.mem_addr  <= bus.mem_addr + ADDR_W'(BYTES);
            bus.mem_be    <= be_hi_q;
            bus.mem_wdata <= wdata_hi_q;
          end else begin
            state         <= RESP;
            bus.mem_req   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= we_q ? '0 : load_result('0, bus.mem_rdata, off_q, ctl_q);
          end
        end
        BEAT2: if (bus.mem_ack) begin
          state         <= RESP;
          bus.mem_req   <= 1'b0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= we_q ? '0 : load_result(bus.mem_rdata, rdata_lo_q, off_q, ctl_q);
        end
        default: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboard bench: directed requests push expected bus beats and responses; a memory
// model and response monitors pop and compare as the unit presents them.
module tb_dm_access_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm_access_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();
  dm_access_if #(.DATA_W(32), .ADDR_W(32)) bus2 ();

  dm_access_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  dm_access_unit #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  // The strict-alignment unit shares request fields and never sees a bus response.
  assign bus2.req_we    = bus1.req_we;
  assign bus2.req_ctl   = bus1.req_ctl;
  assign bus2.req_addr  = bus1.req_addr;
  assign bus2.req_wdata = bus1.req_wdata;
  assign bus2.mem_ack   = 1'b0;
  assign bus2.mem_rdata = '0;

  typedef struct { logic [31:0] rdata; logic err; int due; int id; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } beat_t;

  rsp_t  exp1[$];
  rsp_t  exp2[$];
  beat_t beats[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    wait_cfg = 0;
  int    waited   = 0;
  logic [31:0] mem [0:255];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: every cycle of a beat is checked against the front expectation.
  always @(negedge clk) begin
    bus1.mem_ack = 1'b0;
    if (rst_n === 1'b1 && bus1.mem_req === 1'b1) begin
      if (beats.size() == 0) begin
        chk("bus_unexpected_req", 32'(bus1.mem_req), 32'd0);
        bus1.mem_ack   = 1'b1;
        bus1.mem_rdata = '0;
      end else begin
        beat_t b;
        b = beats[0];
        chk("mem_we",    32'(bus1.mem_we), 32'(b.we));
        chk("mem_addr",  bus1.mem_addr,    b.addr);
        chk("mem_be",    32'(bus1.mem_be), 32'(b.be));
        chk("mem_wdata", bus1.mem_wdata,   b.wdata);
        if (waited < wait_cfg) begin
          waited++;
        end else begin
          waited         = 0;
          bus1.mem_ack   = 1'b1;
          bus1.mem_rdata = mem[bus1.mem_addr[9:2]];
          if (bus1.mem_we)
            for (int i = 0; i < 4; i++)
              if (bus1.mem_be[i]) mem[bus1.mem_addr[9:2]][8*i +: 8] = bus1.mem_wdata[8*i +: 8];
          void'(beats.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.rsp_valid === 1'b1) begin
      if (exp1.size() == 0) begin
        chk("rsp1_unexpected", 32'(bus1.rsp_valid), 32'd0);
      end else begin
        rsp_t e;
        e = exp1.pop_front();
        chk($sformatf("rsp1_rdata[%0d]", e.id), bus1.rsp_rdata, e.rdata);
        chk($sformatf("rsp1_err[%0d]", e.id), 32'(bus1.rsp_err), 32'(e.err));
        chk($sformatf("rsp1_cycle[%0d]", e.id), 32'(cyc), 32'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    if (bus2.mem_req === 1'b1) chk("mem2_req", 32'(bus2.mem_req), 32'd0);
    if (bus2.rsp_valid === 1'b1) begin
      if (exp2.size() == 0) begin
        chk("rsp2_unexpected", 32'(bus2.rsp_valid), 32'd0);
      end else begin
        rsp_t e;
        e = exp2.pop_front();
        chk($sformatf("rsp2_rdata[%0d]", e.id), bus2.rsp_rdata, e.rdata);
        chk($sformatf("rsp2_err[%0d]", e.id), 32'(bus2.rsp_err), 32'(e.err));
        chk($sformatf("rsp2_cycle[%0d]", e.id), 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic beat(input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata);
    beat_t b;
    b.we = we; b.addr = addr; b.be = be; b.wdata = wdata;
    beats.push_back(b);
  endtask

  // lat counts cycles from the accept cycle (cycle 0) to the rsp_valid cycle.
  task automatic issue(input bit sel, input logic we, input logic [2:0] ctl,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input int lat, input bit want_rsp, input int id);
    int n = 0;
    @(negedge clk);
    while ((sel ? bus2.req_ready : bus1.req_ready) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk($sformatf("issue_ready[%0d]", id), 32'd0, 32'd1);
      return;
    end
    bus1.req_we = we; bus1.req_ctl = ctl; bus1.req_addr = addr; bus1.req_wdata = wdata;
    if (sel) bus2.req_valid = 1'b1;
    else     bus1.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus1.req_valid = 1'b0;
    bus2.req_valid = 1'b0;
    if (want_rsp) begin
      rsp_t e;
      e.rdata = exp_rdata; e.err = exp_err; e.due = cyc + lat - 1; e.id = id;
      if (sel) exp2.push_back(e);
      else     exp1.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp1.size() + exp2.size() + beats.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk($sformatf("drain_%s", tag), 32'(exp1.size() + exp2.size() + beats.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus1.req_valid = 1'b0; bus2.req_valid = 1'b0;
    bus1.req_we = 1'b0; bus1.req_ctl = '0; bus1.req_addr = '0; bus1.req_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0]   = 32'h5566_7788;
    mem[64]  = 32'h8899_AABB;
    mem[65]  = 32'hCCDD_EEFF;
    mem[255] = 32'h1122_3344;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_mem_req",   32'(bus1.mem_req),   32'd0);
    chk("reset_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("reset_rsp_err",   32'(bus1.rsp_err),   32'd0);
    chk("reset_rsp_rdata", bus1.rsp_rdata,      32'd0);
    chk("reset_mem_addr",  bus1.mem_addr,       32'd0);
    chk("reset_mem_be",    32'(bus1.mem_be),    32'd0);
    chk("reset_mem_wdata", bus1.mem_wdata,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(bus1.req_ready), 32'd1);

    beat(0, 32'h100, 4'b1000, 0); issue(0, 0, 3'd0, 32'h103, 0, 32'hFFFF_FF88, 0, 2, 1, 1);
    beat(0, 32'h100, 4'b1000, 0); issue(0, 0, 3'd1, 32'h103, 0, 32'h0000_0088, 0, 2, 1, 2);
    beat(0, 32'h100, 4'b1000, 0); beat(0, 32'h104, 4'b0001, 0);
    issue(0, 0, 3'd2, 32'h103, 0, 32'hFFFF_FF88, 0, 3, 1, 3);
    beat(0, 32'h100, 4'b1000, 0); beat(0, 32'h104, 4'b0001, 0);
    issue(0, 0, 3'd3, 32'h103, 0, 32'h0000_FF88, 0, 3, 1, 4);
    beat(0, 32'h100, 4'b1100, 0); beat(0, 32'h104, 4'b0011, 0);
    issue(0, 0, 3'd4, 32'h102, 0, 32'hEEFF_8899, 0, 3, 1, 5);
    beat(0, 32'h100, 4'b1100, 0); issue(0, 0, 3'd2, 32'h102, 0, 32'hFFFF_8899, 0, 2, 1, 6);
    beat(0, 32'h104, 4'b1111, 0); issue(0, 0, 3'd4, 32'h104, 0, 32'hCCDD_EEFF, 0, 2, 1, 7);
    issue(0, 0, 3'd7, 32'h100, 0, 32'h0, 1, 1, 1, 8);
    issue(0, 0, 3'd5, 32'h100, 0, 32'h0, 1, 1, 1, 9);
    beat(0, 32'hFFFF_FFFC, 4'b1100, 0); beat(0, 32'h0, 4'b0011, 0);
    issue(0, 0, 3'd4, 32'hFFFF_FFFE, 0, 32'h7788_1122, 0, 3, 1, 10);

    // Three wait states on a single-beat load.
    drain("pre_wait");
    wait_cfg = 3;
    beat(0, 32'h100, 4'b1111, 0); issue(0, 0, 3'd4, 32'h100, 0, 32'h8899_AABB, 0, 5, 1, 11);
    drain("wait");
    wait_cfg = 0;

    // Reset during the second beat of a split load: no response may follow.
    beat(0, 32'h100, 4'b1100, 0);
    issue(0, 0, 3'd4, 32'h102, 0, 32'h0, 0, 3, 0, 12);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_mem_req",   32'(bus1.mem_req),   32'd0);
    chk("abort_req_ready", 32'(bus1.req_ready), 32'd1);
    chk("abort_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    repeat (4) @(negedge clk);
    beat(0, 32'h104, 4'b1111, 0); issue(0, 0, 3'd4, 32'h104, 0, 32'hCCDD_EEFF, 0, 2, 1, 13);

    beat(1, 32'h100, 4'b1110, 32'h2233_4400); beat(1, 32'h104, 4'b0001, 32'h0000_0011);
    issue(0, 1, 3'd4, 32'h101, 32'h1122_3344, 32'h0, 0, 3, 1, 14);
    beat(0, 32'h100, 4'b1111, 0); issue(0, 0, 3'd4, 32'h100, 0, 32'h2233_44BB, 0, 2, 1, 15);
    beat(1, 32'h104, 4'b1000, 32'h8000_0000);
    issue(0, 1, 3'd0, 32'h107, 32'h0000_0080, 32'h0, 0, 2, 1, 16);
    beat(0, 32'h104, 4'b1111, 0); issue(0, 0, 3'd4, 32'h104, 0, 32'h80DD_EE11, 0, 2, 1, 17);
    beat(0, 32'h104, 4'b1000, 0); issue(0, 0, 3'd0, 32'h107, 0, 32'hFFFF_FF80, 0, 2, 1, 18);

    issue(1, 0, 3'd4, 32'h102, 0, 32'h0, 1, 1, 1, 19);
    issue(1, 0, 3'd7, 32'h100, 0, 32'h0, 1, 1, 1, 20);
    issue(1, 0, 3'd2, 32'h101, 0, 32'h0, 1, 1, 1, 21);

    drain("final");
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
